// File: rtl/button_debounce.sv
// Two-channel push-button conditioner: 2-flop synchroniser, stability counter, registered level
// plus press/release strobes. Define BUTTON_REPEAT_EN to add hold-to-repeat press strobes.
module button_debounce #(
    parameter int DB_CYCLES    = 1000000,
    parameter int CNT_W        = 20,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       button1_i,
    input  logic       button2_i,
    output logic [1:0] level_o,
    output logic [1:0] press_o,
    output logic [1:0] release_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("button_debounce: DB_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
        $error("button_debounce: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_ARM_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } state_t;

    logic [1:0] raw_s;
    logic [1:0] s1_q;
    logic [1:0] s2_q;

    // Pins are active-low; invert before synchronising so internal logic is active-high.
    assign raw_s = {button2_i, button1_i};

    // Two-flop synchroniser for both channels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= ~raw_s;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d, press_edge_s;
        logic             release_q, release_d;
        logic             rpt_fire_s;

        // Stability counter FSM: any agreeing sample while arming returns to the origin state.
        always_comb begin
            state_d      = state_q;
            cnt_d        = {CNT_W{1'b0}};
            level_d      = level_q;
            press_edge_s = 1'b0;
            release_d    = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (s2_q[i]) begin
                        state_d = ST_ARM_PRESS;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ST_RELEASED;
                    end
                end
                ST_ARM_PRESS: begin
                    if (!s2_q[i]) begin
                        state_d = ST_RELEASED;
                    end else if (cnt_q == DB_LAST) begin
                        state_d      = ST_PRESSED;
                        level_d      = 1'b1;
                        press_edge_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!s2_q[i]) begin
                        state_d = ST_ARM_RELEASE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_ARM_RELEASE: begin
                    if (s2_q[i]) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = ST_RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    level_d = 1'b0;
                end
            endcase
        end

`ifdef BUTTON_REPEAT_EN
        localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

        logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             rpt_first_q, rpt_first_d;

        // Repeat timer runs only while held; suppressed on the release cycle so strobes never overlap.
        always_comb begin
            rpt_cnt_d   = rpt_cnt_q;
            rpt_first_d = rpt_first_q;
            rpt_fire_s  = 1'b0;
            if (!level_q || release_d) begin
                rpt_cnt_d   = {CNT_W{1'b0}};
                rpt_first_d = 1'b0;
            end else if (rpt_cnt_q == (rpt_first_q ? RATE_LAST : DELAY_LAST)) begin
                rpt_cnt_d   = {CNT_W{1'b0}};
                rpt_first_d = 1'b1;
                rpt_fire_s  = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            end
        end

        // Repeat timer registers.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rpt_cnt_q   <= {CNT_W{1'b0}};
                rpt_first_q <= 1'b0;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_first_q <= rpt_first_d;
            end
        end
`else
        assign rpt_fire_s = 1'b0;
`endif

        assign press_d = press_edge_s | rpt_fire_s;

        // Channel state and registered outputs.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q   <= ST_RELEASED;
                cnt_q     <= {CNT_W{1'b0}};
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign level_o[i]   = level_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed, table-driven bench for button_debounce (DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5).
module tb_button_debounce;

`ifdef BUTTON_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       b1;
    logic       b2;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       b1;
        logic       b2;
        int         n;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rls;
    } vec_t;

    vec_t tbl[$];

    button_debounce #(
        .DB_CYCLES   (8),
        .CNT_W       (8),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .button1_i(b1),
        .button2_i(b2),
        .level_o  (level),
        .press_o  (press),
        .release_o(rel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] l, input logic [1:0] p, input logic [1:0] r);
        checks++;
        if ({level, press, rel} !== {l, p, r}) begin
            errors++;
            $display("FAIL %s t=%0t: level/press/release got %b/%b/%b expected %b/%b/%b",
                     name, $time, level, press, rel, l, p, r);
        end
    endtask

    // Drive pins now (at a negedge), check after the next posedge, return at the following negedge.
    task automatic step(input logic i1, input logic i2, input string name,
                        input logic [1:0] l, input logic [1:0] p, input logic [1:0] r);
        b1 = i1;
        b2 = i2;
        @(posedge clk);
        #1;
        chk(name, l, p, r);
        @(negedge clk);
    endtask

    task automatic add(input logic i1, input logic i2, input int n,
                       input logic [1:0] l, input logic [1:0] p, input logic [1:0] r);
        vec_t v;
        v.b1  = i1;
        v.b2  = i2;
        v.n   = n;
        v.lvl = l;
        v.prs = p;
        v.rls = r;
        tbl.push_back(v);
    endtask

    initial begin
        // clean press / release on button1
        add(1'b0, 1'b1, 9, 2'b00, 2'b00, 2'b00);
        add(1'b0, 1'b1, 1, 2'b01, 2'b01, 2'b00);
        add(1'b0, 1'b1, 5, 2'b01, 2'b00, 2'b00);
        add(1'b1, 1'b1, 9, 2'b01, 2'b00, 2'b00);
        add(1'b1, 1'b1, 1, 2'b00, 2'b00, 2'b01);
        add(1'b1, 1'b1, 3, 2'b00, 2'b00, 2'b00);
        // press, then 7-cycle high glitch is rejected, then real release
        add(1'b0, 1'b1, 9, 2'b00, 2'b00, 2'b00);
        add(1'b0, 1'b1, 1, 2'b01, 2'b01, 2'b00);
        add(1'b1, 1'b1, 7, 2'b01, 2'b00, 2'b00);
        add(1'b0, 1'b1, 2, 2'b01, 2'b00, 2'b00);
        add(1'b1, 1'b1, 9, 2'b01, 2'b00, 2'b00);
        add(1'b1, 1'b1, 1, 2'b00, 2'b00, 2'b01);
        add(1'b1, 1'b1, 3, 2'b00, 2'b00, 2'b00);
        // press, then an 8-cycle high pulse is exactly long enough to release; re-press follows
        add(1'b0, 1'b1, 9, 2'b00, 2'b00, 2'b00);
        add(1'b0, 1'b1, 1, 2'b01, 2'b01, 2'b00);
        add(1'b1, 1'b1, 8, 2'b01, 2'b00, 2'b00);
        add(1'b0, 1'b1, 1, 2'b01, 2'b00, 2'b00);
        add(1'b0, 1'b1, 1, 2'b00, 2'b00, 2'b01);
        add(1'b0, 1'b1, 7, 2'b00, 2'b00, 2'b00);
        add(1'b0, 1'b1, 1, 2'b01, 2'b01, 2'b00);
        add(1'b1, 1'b1, 9, 2'b01, 2'b00, 2'b00);
        add(1'b1, 1'b1, 1, 2'b00, 2'b00, 2'b01);
        add(1'b1, 1'b1, 3, 2'b00, 2'b00, 2'b00);
        // bounce on button2: low 5 / high 1 / low
        add(1'b1, 1'b0, 5, 2'b00, 2'b00, 2'b00);
        add(1'b1, 1'b1, 1, 2'b00, 2'b00, 2'b00);
        add(1'b1, 1'b0, 9, 2'b00, 2'b00, 2'b00);
        add(1'b1, 1'b0, 1, 2'b10, 2'b10, 2'b00);
        add(1'b1, 1'b0, 3, 2'b10, 2'b00, 2'b00);
        add(1'b1, 1'b1, 9, 2'b10, 2'b00, 2'b00);
        add(1'b1, 1'b1, 1, 2'b00, 2'b00, 2'b10);
        add(1'b1, 1'b1, 3, 2'b00, 2'b00, 2'b00);
        // simultaneous press and release
        add(1'b0, 1'b0, 9, 2'b00, 2'b00, 2'b00);
        add(1'b0, 1'b0, 1, 2'b11, 2'b11, 2'b00);
        add(1'b0, 1'b0, 3, 2'b11, 2'b00, 2'b00);
        add(1'b1, 1'b1, 9, 2'b11, 2'b00, 2'b00);
        add(1'b1, 1'b1, 1, 2'b00, 2'b00, 2'b11);
        add(1'b1, 1'b1, 3, 2'b00, 2'b00, 2'b00);

        rst = 1'b1;
        b1  = 1'b1;
        b2  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 2'b00, 2'b00, 2'b00);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                step(tbl[r].b1, tbl[r].b2, $sformatf("row%0d_cyc%0d", r, c),
                     tbl[r].lvl, tbl[r].prs, tbl[r].rls);
            end
        end

        // hold button1 45 cycles past acceptance, then release
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 1'b1, "hold_arm", 2'b00, 2'b00, 2'b00);
        end
        step(1'b0, 1'b1, "hold_accept", 2'b01, 2'b01, 2'b00);
        for (int k = 1; k <= 60; k++) begin
            logic       pin;
            logic [1:0] el;
            logic [1:0] ep;
            logic [1:0] er;
            pin = (k <= 45) ? 1'b0 : 1'b1;
            el  = (k < 55) ? 2'b01 : 2'b00;
            ep  = (REP && k >= 20 && k < 55 && ((k - 20) % 5) == 0) ? 2'b01 : 2'b00;
            er  = (k == 55) ? 2'b01 : 2'b00;
            step(pin, 1'b1, $sformatf("hold_k%0d", k), el, ep, er);
        end

        // asynchronous reset mid-cycle while both are held, then button1 held through reset
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 1'b0, "pre_rst_arm", 2'b00, 2'b00, 2'b00);
        end
        step(1'b0, 1'b0, "pre_rst_accept", 2'b11, 2'b11, 2'b00);
        step(1'b0, 1'b0, "pre_rst_hold", 2'b11, 2'b00, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk("reset_held", 2'b00, 2'b00, 2'b00);
        b2  = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step(1'b0, 1'b1, "post_rst_arm", 2'b00, 2'b00, 2'b00);
        end
        step(1'b0, 1'b1, "post_rst_press", 2'b01, 2'b01, 2'b00);
        step(1'b0, 1'b1, "post_rst_hold", 2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
